// File: rtl/recv_pkg.sv
// Shared types and default widths for the receive matcher, the CAM and the network writer.
package recv_pkg;

    localparam int PKT_WIDTH_DEF  = 128;
    localparam int ADDR_WIDTH_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WAIT,
        DELIVER
    } state_t;

endpackage

// File: rtl/recv_matcher_if.sv
// Host request/response handshake plus CAM port-B read and write-snoop signals.
interface recv_matcher_if
    import recv_pkg::*;
#(
    parameter int PACKETIZER_WIDTH = PKT_WIDTH_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF
);
    logic                        req_valid;
    logic                        req_ready;
    logic [ADDR_WIDTH-1:0]       req_src;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [PACKETIZER_WIDTH-1:0] resp_data;
    logic                        resp_timeout;
    logic                        cam_re_b;
    logic [ADDR_WIDTH-1:0]       cam_addr_b;
    logic [PACKETIZER_WIDTH-1:0] cam_q_b;
    logic                        cam_we_a;

    // master = host and CAM side, slave = matcher
    modport master (
        output req_valid, req_src, resp_ready, cam_q_b, cam_we_a,
        input  req_ready, resp_valid, resp_data, resp_timeout, cam_re_b, cam_addr_b
    );

    modport slave (
        input  req_valid, req_src, resp_ready, cam_q_b, cam_we_a,
        output req_ready, resp_valid, resp_data, resp_timeout, cam_re_b, cam_addr_b
    );

endinterface

// File: rtl/recv_matcher.sv
// Polls one CAM slot with backoff until a packet appears or the poll limit expires,
// then returns the payload or a timeout to the host.
//
//   state   | meaning
//   IDLE    | waiting for a receive request
//   READ    | issue CAM read (stalls while the network writes)
//   CHECK   | inspect read data: hit, miss, or timeout
//   WAIT    | backoff between polls
//   DELIVER | response held until the host takes it
module recv_matcher
    import recv_pkg::*;
#(
    parameter int PACKETIZER_WIDTH = PKT_WIDTH_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int MAX_POLLS        = 16,
    parameter int BACKOFF          = 4
) (
    input  logic          clk,
    input  logic          rst,
    recv_matcher_if.slave bus,
    output logic          busy
);

    localparam logic [15:0] POLL_LIMIT   = 16'(MAX_POLLS);
    localparam logic [15:0] BACKOFF_LOAD = (BACKOFF > 0) ? 16'(BACKOFF - 1) : 16'd0;

    state_t                      state;
    state_t                      state_nxt;
    logic [ADDR_WIDTH-1:0]       src_q;
    logic [15:0]                 poll_cnt;
    logic [15:0]                 backoff_cnt;
    logic [15:0]                 poll_inc;
    logic [PACKETIZER_WIDTH-1:0] data_q;
    logic                        timeout_q;
    logic                        hit;
    logic                        limit_hit;
    logic                        req_ready_c;
    logic                        resp_valid_c;
    logic                        cam_re_c;

    // An all-zero word is indistinguishable from an empty slot.
    assign hit       = |bus.cam_q_b;
    assign poll_inc  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    assign limit_hit = (MAX_POLLS != 0) && (poll_inc == POLL_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        cam_re_c     = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_nxt = READ;
            end
            READ: begin
                if (!bus.cam_we_a) begin
                    cam_re_c  = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (hit || limit_hit)  state_nxt = DELIVER;
                else if (BACKOFF == 0) state_nxt = READ;
                else                   state_nxt = WAIT;
            end
            WAIT: begin
                if (backoff_cnt == 16'd0) state_nxt = READ;
            end
            DELIVER: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '0;
            poll_cnt    <= '0;
            backoff_cnt <= '0;
            data_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        src_q    <= bus.req_src;
                        poll_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        data_q    <= bus.cam_q_b;
                        timeout_q <= 1'b0;
                    end else begin
                        poll_cnt <= poll_inc;
                        if (limit_hit) begin
                            data_q    <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            backoff_cnt <= BACKOFF_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (backoff_cnt != 16'd0) backoff_cnt <= backoff_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign bus.req_ready    = req_ready_c & ~rst;
    assign bus.resp_valid   = resp_valid_c & ~rst;
    assign bus.cam_re_b     = cam_re_c & ~rst;
    assign bus.cam_addr_b   = src_q;
    assign bus.resp_data    = data_q;
    assign bus.resp_timeout = timeout_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_recv_matcher.sv
// Directed bench: CAM slot model on port B, network writes through cam_we_a.
module tb_recv_matcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    recv_matcher_if #(.PACKETIZER_WIDTH(128), .ADDR_WIDTH(2)) bus ();
    recv_matcher_if #(.PACKETIZER_WIDTH(128), .ADDR_WIDTH(2)) bus_t ();
    logic busy;
    logic busy_t;

    recv_matcher #(.PACKETIZER_WIDTH(128), .ADDR_WIDTH(2), .MAX_POLLS(16), .BACKOFF(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy)
    );

    recv_matcher #(.PACKETIZER_WIDTH(128), .ADDR_WIDTH(2), .MAX_POLLS(3), .BACKOFF(0)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t.slave), .busy(busy_t)
    );

    // CAM model: a read returns the slot and clears it, network writes land on the edge.
    logic [127:0] cam_mem [4];
    logic [1:0]   net_addr = 2'd0;
    logic [127:0] net_data = '0;
    int cyc      = 0;
    int pulses   = 0;
    int pulses_t = 0;
    int coll     = 0;
    int pulse_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 4; i++) cam_mem[i] <= '0;
            bus.cam_q_b <= '0;
        end else begin
            if (bus.cam_re_b) begin
                bus.cam_q_b <= cam_mem[bus.cam_addr_b];
                cam_mem[bus.cam_addr_b] <= '0;
                pulses <= pulses + 1;
                pulse_cyc.push_back(cyc);
            end
            if (bus.cam_we_a) cam_mem[net_addr] <= net_data;
        end
        if (bus.cam_re_b && bus.cam_we_a) coll <= coll + 1;
        if (bus_t.cam_re_b) pulses_t <= pulses_t + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [1:0] src);
        bus.req_src   = src;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic net_write(input logic [1:0] a, input logic [127:0] d);
        net_addr     = a;
        net_data     = d;
        bus.cam_we_a = 1'b1;
        @(negedge clk);
        bus.cam_we_a = 1'b0;
    endtask

    // n = number of negedges since acceptance at which resp_valid is first seen
    task automatic wait_resp(input int start, input int budget, output int n);
        n = start;
        while (!bus.resp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("ack_req_ready", 128'(bus.req_ready), 128'd1);
    endtask

    int n;
    int p0;
    int c0;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_src      = 2'd0;
        bus.resp_ready   = 1'b0;
        bus.cam_we_a     = 1'b0;
        bus_t.req_valid  = 1'b0;
        bus_t.req_src    = 2'd0;
        bus_t.resp_ready = 1'b0;
        bus_t.cam_we_a   = 1'b0;
        bus_t.cam_q_b    = '0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  128'(bus.req_ready),    128'd0);
        chk("rst_resp_valid", 128'(bus.resp_valid),   128'd0);
        chk("rst_resp_data",  bus.resp_data,          128'd0);
        chk("rst_timeout",    128'(bus.resp_timeout), 128'd0);
        chk("rst_cam_re",     128'(bus.cam_re_b),     128'd0);
        chk("rst_cam_addr",   128'(bus.cam_addr_b),   128'd0);
        chk("rst_busy",       128'(busy),             128'd0);
        rst = 1'b0;
        #1 chk("rel_req_ready", 128'(bus.req_ready), 128'd1);
        @(negedge clk);

        // hit on first poll
        net_write(2'd2, 128'hA5);
        p0 = pulses;
        send_req(2'd2);
        chk("hit_re",   128'(bus.cam_re_b),   128'd1);
        chk("hit_addr", 128'(bus.cam_addr_b), 128'd2);
        wait_resp(1, 10, n);
        chk("hit_lat",    128'(n),                128'd3);
        chk("hit_data",   bus.resp_data,          128'hA5);
        chk("hit_to",     128'(bus.resp_timeout), 128'd0);
        chk("hit_pulses", 128'(pulses - p0),      128'd1);
        chk("hit_tag",    cam_mem[2],             128'd0);
        ack();

        // late arrival: reads every 6 cycles until the write lands
        p0 = pulses;
        pulse_cyc.delete();
        send_req(2'd1);
        fork
            begin
                repeat (19) @(negedge clk);
                net_write(2'd1, 128'h1234);
            end
            wait_resp(1, 60, n);
        join
        chk("late_lat",    128'(n),           128'd27);
        chk("late_data",   bus.resp_data,     128'h1234);
        chk("late_pulses", 128'(pulses - p0), 128'd5);
        if (pulse_cyc.size() >= 2)
            chk("late_gap", 128'(pulse_cyc[1] - pulse_cyc[0]), 128'd6);
        else
            chk("late_gap_count", 128'(pulse_cyc.size()), 128'd5);
        ack();

        // write collision: cam_we_a high for 3 cycles starting in READ
        net_write(2'd0, 128'hBEEF);
        p0 = pulses;
        c0 = coll;
        send_req(2'd0);
        net_addr     = 2'd3;
        net_data     = 128'h77;
        bus.cam_we_a = 1'b1;
        #1 chk("coll_re_low", 128'(bus.cam_re_b), 128'd0);
        repeat (3) @(negedge clk);
        bus.cam_we_a = 1'b0;
        wait_resp(4, 20, n);
        chk("coll_lat",    128'(n),           128'd6);
        chk("coll_data",   bus.resp_data,     128'hBEEF);
        chk("coll_pulses", 128'(pulses - p0), 128'd1);
        chk("coll_overlap", 128'(coll - c0),  128'd0);
        ack();

        // same slot again is now empty -> timeout after 16 polls
        p0 = pulses;
        send_req(2'd0);
        wait_resp(1, 120, n);
        chk("to_lat",    128'(n),                128'd93);
        chk("to_flag",   128'(bus.resp_timeout), 128'd1);
        chk("to_data",   bus.resp_data,          128'd0);
        chk("to_pulses", 128'(pulses - p0),      128'd16);
        ack();

        // backpressure with a pending request held on the bus
        send_req(2'd3);
        wait_resp(1, 10, n);
        chk("bp_lat", 128'(n), 128'd3);
        p0 = pulses;
        bus.req_src   = 2'd2;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",     128'(bus.resp_valid), 128'd1);
            chk("bp_data",      bus.resp_data,        128'h77);
            chk("bp_req_ready", 128'(bus.req_ready),  128'd0);
            @(negedge clk);
        end
        chk("bp_pulses", 128'(pulses - p0), 128'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("bp_idle_ready", 128'(bus.req_ready),  128'd1);
        chk("bp_idle_valid", 128'(bus.resp_valid), 128'd0);
        chk("bp_not_taken",  128'(busy),           128'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_taken_busy",  128'(busy),          128'd1);
        chk("bp_taken_ready", 128'(bus.req_ready), 128'd0);

        // reset during WAIT (slot 2 is empty)
        repeat (2) @(negedge clk);
        chk("wait_busy", 128'(busy),         128'd1);
        chk("wait_re",   128'(bus.cam_re_b), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_req_ready",  128'(bus.req_ready),    128'd0);
        chk("mid_resp_valid", 128'(bus.resp_valid),   128'd0);
        chk("mid_resp_data",  bus.resp_data,          128'd0);
        chk("mid_timeout",    128'(bus.resp_timeout), 128'd0);
        chk("mid_cam_re",     128'(bus.cam_re_b),     128'd0);
        chk("mid_cam_addr",   128'(bus.cam_addr_b),   128'd0);
        chk("mid_busy",       128'(busy),             128'd0);
        rst = 1'b0;
        #1 chk("mid_rel_ready", 128'(bus.req_ready), 128'd1);
        @(negedge clk);
        net_write(2'd1, 128'h55AA);
        send_req(2'd1);
        wait_resp(1, 10, n);
        chk("post_lat",  128'(n),       128'd3);
        chk("post_data", bus.resp_data, 128'h55AA);
        ack();

        // MAX_POLLS=3, BACKOFF=0 instance on an empty slot
        p0 = pulses_t;
        bus_t.req_src   = 2'd0;
        bus_t.req_valid = 1'b1;
        @(negedge clk);
        bus_t.req_valid = 1'b0;
        n = 1;
        while (!bus_t.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t_lat",    128'(n),                  128'd7);
        chk("t_flag",   128'(bus_t.resp_timeout), 128'd1);
        chk("t_data",   bus_t.resp_data,          128'd0);
        chk("t_pulses", 128'(pulses_t - p0),      128'd3);
        chk("t_busy",   128'(busy_t),             128'd1);
        bus_t.resp_ready = 1'b1;
        @(negedge clk);
        bus_t.resp_ready = 1'b0;
        chk("t_ready", 128'(bus_t.req_ready), 128'd1);

        chk("no_overlap", 128'(coll), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/recv_matcher.md
# recv_matcher

Receive-side matcher sitting directly downstream of the CAM's read port (port B) in the Nios receive accelerator. It accepts one receive request at a time naming a source slot and reads that CAM slot. It polls with a programmable backoff until an eagerly-sent packet is present or a poll limit expires, then hands the 128-bit payload, or a timeout indication, to the host over a valid/ready handshake. It also enforces the CAM's read/write exclusion rule, so a read is never issued in a cycle where the network is writing.

## Interface
- PACKETIZER_WIDTH, 128, payload width; must equal the CAM's data_b/q_b width.
- ADDR_WIDTH, 2, CAM slot address width (source-rank index).
- MAX_POLLS, 16, CAM reads that may miss before a timeout response; 0 = poll forever.
- BACKOFF, 4, idle cycles between a miss and the next read; 0 = re-read immediately.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  host presents a receive request.
- req_ready  out  1  matcher can accept a request (high only in IDLE).
- req_src  in  ADDR_WIDTH  source slot to match.
- resp_valid  out  1  response held on resp_data/resp_timeout.
- resp_ready  in  1  host consumes the response.
- resp_data  out  PACKETIZER_WIDTH  matched payload; 0 on timeout.
- resp_timeout  out  1  response is a timeout, not data.
- cam_re_b  out  1  CAM port-B read enable.
- cam_addr_b  out  ADDR_WIDTH  CAM port-B address.
- cam_q_b  in  PACKETIZER_WIDTH  CAM port-B data; registered by the CAM, valid the cycle after cam_re_b.
- cam_we_a  in  1  snoop of the CAM's network write enable.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, READ, CHECK, WAIT, DELIVER.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_src into src_q, clear poll_cnt, go to READ.
- READ: drive cam_addr_b=src_q.
  - If cam_we_a=1, hold cam_re_b=0 and stay in READ (stall). This avoids the CAM returning data without clearing the slot's valid tag.
  - Otherwise drive cam_re_b=1 for exactly this cycle, then go to CHECK.
- CHECK: evaluate cam_q_b. An all-zero value means the slot is empty.
  - Hit (nonzero): latch cam_q_b into resp_data, set resp_timeout=0, go to DELIVER.
  - Miss: increment poll_cnt (saturating, 16 bits).
    - If MAX_POLLS≠0 and poll_cnt+1==MAX_POLLS: set resp_data=0, resp_timeout=1, go to DELIVER.
    - Else, if BACKOFF=0 go to READ; otherwise load backoff_cnt=BACKOFF-1 and go to WAIT.
- WAIT: decrement backoff_cnt; on 0, go to READ.
- DELIVER: resp_valid=1, with resp_data and resp_timeout stable. On resp_ready, go to IDLE.
- cam_addr_b always equals src_q. It is don't-care when cam_re_b=0 but must not toggle mid-request.
- An all-zero payload cannot be distinguished from an empty slot. Senders must not emit an all-zero payload; the block treats it as a miss.

## Timing
- Reset values: req_ready=0 while rst=1, then 1 in the first cycle after release. resp_valid=0, resp_data=0, resp_timeout=0, cam_re_b=0, cam_addr_b=0, busy=0. State=IDLE, counters=0.
- Hit latency, with request accepted at edge E0 and no stall: cam_re_b high in cycle E0→E1, CHECK in E1→E2, resp_valid high from E2.
- Each miss adds 2+BACKOFF cycles. Each cam_we_a stall cycle adds 1 cycle.
- Exactly one cam_re_b pulse per poll. No cam_re_b in any cycle where cam_we_a=1.
- A simultaneous req_valid and resp_ready in DELIVER does not accept the new request; it is accepted the cycle after returning to IDLE.
- resp_valid stays asserted indefinitely until resp_ready. No further CAM reads occur while in DELIVER.
- rst asserted in any state: next state IDLE and all outputs at reset values. Any in-flight request is dropped, and any CAM slot already read is lost; this is acceptable.

## Structure
- Shared package recv_pkg: state enum (IDLE, READ, CHECK, WAIT, DELIVER) and the default PACKETIZER_WIDTH and ADDR_WIDTH constants. The CAM and the network writer use the same widths.
- Single flat module; no sub-module needed. The backoff and poll counters stay inline.

## Test plan
- Hit on first poll: preload CAM slot 2 with 128'hA5; send req_src=2 → one cam_re_b pulse at addr 2; resp_valid two cycles after acceptance with resp_data=128'hA5, resp_timeout=0; CAM slot 2 tag cleared.
- Late arrival: request slot 1 on an empty CAM with BACKOFF=4; the network writes 128'h1234 to slot 1 after 20 cycles → misses spaced 6 cycles apart, then resp_data=128'h1234.
- Timeout: MAX_POLLS=3 on an empty slot 0 → exactly 3 cam_re_b pulses, then resp_valid with resp_timeout=1 and resp_data=0.
- Write collision: hold cam_we_a=1 for 3 cycles starting in the READ cycle → cam_re_b delayed 3 cycles and never coincident with cam_we_a; the data is returned once, and a second request to the same slot times out.
- Backpressure: hold resp_ready=0 for 10 cycles after a hit → resp_valid and resp_data stable, req_ready=0, no CAM reads; handshake completes and req_ready=1 on the next cycle.
- Reset mid-operation: assert rst during WAIT → next cycle all outputs at reset values; a following request to a preloaded slot completes normally.
